// File: rtl/apb_i2c_pkg.sv
// Shared types and constants for the APB front-end of the I2C controller
// register file.
//   apb_state_t    : bridge FSM encoding (IDLE -> WAIT -> DONE -> IDLE)
//   REG_ADDR_W     : register file address width
//   REG_DATA_W     : register file data width
//   STATUS_REG_IDX : index of the read-only I2C status register
//   CNT_W          : width of the wait-state down-counter
package apb_i2c_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } apb_state_t;

  localparam int REG_ADDR_W      = 3;
  localparam int REG_DATA_W      = 8;
  localparam int STATUS_REG_IDX  = 7;
  localparam int CNT_W           = 4;
  localparam int MAX_WAIT_STATES = (1 << CNT_W) - 1;

endpackage

// File: rtl/apb_reg_bridge.sv
// APB3 slave front-end for the 8 x 8-bit I2C controller register file.
// Converts APB transfers into regfile write strobes and a read-port address,
// inserts WAIT_STATES extra access cycles, and reports bad accesses
// (out-of-range address, write to a read-only register) with pslverr.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no transfer; a setup phase latches address/direction/data
// WAIT    | access phase, counting down wait states; pready low
// DONE    | single response cycle; pready high, write strobe if legal
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   psel, penable, pwrite         APB control
//   paddr [ADDR_W], pwdata [8]    APB address / write data
//   pready, prdata, pslverr       registered APB response
//   reg_write_addr/data/en        regfile write port (strobe in DONE only)
//   reg_read_addr, reg_read_data  regfile read port (combinational data)
module apb_reg_bridge
  import apb_i2c_pkg::*;
#(
  parameter int                          NUM_REGS    = 8,
  parameter int                          ADDR_W      = 8,
  parameter int                          WAIT_STATES = 0,
  parameter logic [(1<<REG_ADDR_W)-1:0]  RO_MASK     = 8'(1 << STATUS_REG_IDX)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_W-1:0]     paddr,
  input  logic [REG_DATA_W-1:0] pwdata,
  output logic                  pready,
  output logic [REG_DATA_W-1:0] prdata,
  output logic                  pslverr,
  output logic [REG_ADDR_W-1:0] reg_write_addr,
  output logic [REG_DATA_W-1:0] reg_write_data,
  output logic                  reg_write_en,
  output logic [REG_ADDR_W-1:0] reg_read_addr,
  input  logic [REG_DATA_W-1:0] reg_read_data
);

  if (WAIT_STATES < 0 || WAIT_STATES > MAX_WAIT_STATES) begin : g_bad_wait_states
    $error("apb_reg_bridge: WAIT_STATES must be in 0..15");
  end
  if (NUM_REGS < 1 || NUM_REGS > (1 << REG_ADDR_W)) begin : g_bad_num_regs
    $error("apb_reg_bridge: NUM_REGS must be in 1..8");
  end
  if (ADDR_W < REG_ADDR_W) begin : g_bad_addr_w
    $error("apb_reg_bridge: ADDR_W must be at least 3");
  end

  // One extra bit so NUM_REGS is representable even when it equals 2**ADDR_W.
  localparam logic [ADDR_W:0] NUM_REGS_EXT = (ADDR_W+1)'(NUM_REGS);

  apb_state_t              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    write_q, write_d;
  logic [REG_DATA_W-1:0]   wdata_q, wdata_d;
  logic                    pready_q, pready_d;
  logic [REG_DATA_W-1:0]   prdata_q, prdata_d;
  logic                    pslverr_q, pslverr_d;
  logic                    wen_q, wen_d;

  logic                    in_range;
  logic                    acc_err;

  // Full latched address takes part in the range check; only the low bits
  // select a register.
  assign in_range = ({1'b0, addr_q} < NUM_REGS_EXT);
  assign acc_err  = !in_range || (write_q && RO_MASK[addr_q[REG_ADDR_W-1:0]]);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    wen_d     = 1'b0;
    prdata_d  = prdata_q;

    case (state_q)
      ST_IDLE: begin
        if (psel && !penable) begin
          addr_d  = paddr;
          write_d = pwrite;
          wdata_d = pwdata;
          cnt_d   = CNT_W'(WAIT_STATES);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A master that drops the transfer mid-access gets no response.
        if (!psel || !penable) begin
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d   = ST_DONE;
          pready_d  = 1'b1;
          pslverr_d = acc_err;
          wen_d     = write_q && !acc_err;
          prdata_d  = (!write_q && !acc_err) ? reg_read_data : '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      wen_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      wen_q     <= wen_d;
    end
  end

  assign pready         = pready_q;
  assign prdata         = prdata_q;
  assign pslverr        = pslverr_q;
  assign reg_write_en   = wen_q;
  assign reg_write_addr = addr_q[REG_ADDR_W-1:0];
  assign reg_write_data = wdata_q;
  assign reg_read_addr  = addr_q[REG_ADDR_W-1:0];

endmodule
